// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; polarity helpers map an active-high
// value onto the board pin level; calc_div turns clock/dwell into clk cycles.
package sevenseg_pkg;

  localparam int unsigned SEG_W   = 8;
  localparam int unsigned GLYPH_W = 7;

  localparam logic [GLYPH_W-1:0] GLYPH_0 = 7'h3F;
  localparam logic [GLYPH_W-1:0] GLYPH_1 = 7'h06;
  localparam logic [GLYPH_W-1:0] GLYPH_2 = 7'h5B;
  localparam logic [GLYPH_W-1:0] GLYPH_3 = 7'h4F;
  localparam logic [GLYPH_W-1:0] GLYPH_4 = 7'h66;
  localparam logic [GLYPH_W-1:0] GLYPH_5 = 7'h6D;
  localparam logic [GLYPH_W-1:0] GLYPH_6 = 7'h7D;
  localparam logic [GLYPH_W-1:0] GLYPH_7 = 7'h07;
  localparam logic [GLYPH_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [GLYPH_W-1:0] GLYPH_9 = 7'h6F;
  localparam logic [GLYPH_W-1:0] GLYPH_A = 7'h77;
  localparam logic [GLYPH_W-1:0] GLYPH_B = 7'h7C;  // lower-case b
  localparam logic [GLYPH_W-1:0] GLYPH_C = 7'h39;
  localparam logic [GLYPH_W-1:0] GLYPH_D = 7'h5E;  // lower-case d
  localparam logic [GLYPH_W-1:0] GLYPH_E = 7'h79;
  localparam logic [GLYPH_W-1:0] GLYPH_F = 7'h71;

  // Dwell length in clk cycles.
  function automatic int unsigned calc_div(input int unsigned clkfreq,
                                           input int unsigned scan_us);
    return (clkfreq / 32'd1000000) * scan_us;
  endfunction

  // Single pin level from an active-high request.
  function automatic logic pol_bit(input logic active, input logic act_low);
    return active ^ act_low;
  endfunction

  // Segment bus level from an active-high {dp,g..a} request.
  function automatic logic [SEG_W-1:0] pol_seg(input logic [SEG_W-1:0] active,
                                               input logic act_low);
    return active ^ {SEG_W{act_low}};
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment glyph.
// Ports: nib (4-bit hex value) -> glyph_c ({g,f,e,d,c,b,a}, active-high).
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0]         nib,
  output logic [GLYPH_W-1:0] glyph_c
);

  always_comb begin
    glyph_c = GLYPH_0;
    unique case (nib)
      4'h0: glyph_c = GLYPH_0;
      4'h1: glyph_c = GLYPH_1;
      4'h2: glyph_c = GLYPH_2;
      4'h3: glyph_c = GLYPH_3;
      4'h4: glyph_c = GLYPH_4;
      4'h5: glyph_c = GLYPH_5;
      4'h6: glyph_c = GLYPH_6;
      4'h7: glyph_c = GLYPH_7;
      4'h8: glyph_c = GLYPH_8;
      4'h9: glyph_c = GLYPH_9;
      4'hA: glyph_c = GLYPH_A;
      4'hB: glyph_c = GLYPH_B;
      4'hC: glyph_c = GLYPH_C;
      4'hD: glyph_c = GLYPH_D;
      4'hE: glyph_c = GLYPH_E;
      4'hF: glyph_c = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan driver for NDIG digits on a shared segment bus.
// One digit is driven per dwell period; inputs are snapshotted once per frame so
// a frame never shows a mix of old and new values. Adds leading-zero suppression,
// per-digit blank/blink, PWM brightness and a dead cycle at each dwell start.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   dat         4*NDIG hex nibbles, digit 0 in dat[3:0] (rightmost)
//   dp          per-digit decimal point
//   blank       per-digit force dark
//   blink       per-digit dark during blink-off phase
//   lz_en       leading-zero suppression enable
//   bright      live PWM brightness, 0 = dark
//   an          anode enables (AN_ACT_LOW polarity), registered
//   seg         {dp,g,f,e,d,c,b,a} (SEG_ACT_LOW polarity), registered
//   ce_tick     one-clk pulse in the last cycle of each dwell
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned CLKFREQ      = 27000000,
  parameter int unsigned NDIG         = 4,
  parameter int unsigned SCAN_US      = 1000,
  parameter int unsigned PWM_BITS     = 4,
  parameter int unsigned BLINK_FRAMES = 128,
  parameter int unsigned AN_ACT_LOW   = 1,
  parameter int unsigned SEG_ACT_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*NDIG-1:0]     dat,
  input  logic [NDIG-1:0]       dp,
  input  logic [NDIG-1:0]       blank,
  input  logic [NDIG-1:0]       blink,
  input  logic                  lz_en,
  input  logic [PWM_BITS-1:0]   bright,
  output logic [NDIG-1:0]       an,
  output logic [SEG_W-1:0]      seg,
  output logic                  ce_tick
);

  localparam int unsigned DIV     = calc_div(CLKFREQ, SCAN_US);
  localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic AN_LOW  = (AN_ACT_LOW != 0);
  localparam logic SEG_LOW = (SEG_ACT_LOW != 0);

  // Elaboration-time parameter sanity.
  if (NDIG < 1) begin : g_bad_ndig
    $error("sevenseg_scan_ctrl: NDIG must be >= 1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("sevenseg_scan_ctrl: BLINK_FRAMES must be >= 1");
  end
  if (DIV < (32'd1 << PWM_BITS)) begin : g_bad_div
    $error("sevenseg_scan_ctrl: dwell shorter than one PWM period");
  end

  logic [PRESC_W-1:0]  presc;
  logic [IDX_W-1:0]    idx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_sat;
  logic [FRAME_W-1:0]  frame_cnt;
  logic                blink_on;

  logic [3:0]          nib_snap [NDIG];
  logic [NDIG-1:0]     dp_snap;
  logic [NDIG-1:0]     blank_snap;
  logic [NDIG-1:0]     blink_snap;
  logic                lz_snap;

  logic                frame_start;
  logic [NDIG-1:0]     supp;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic [GLYPH_W-1:0]  glyph;
  logic                pwm_on;
  logic                dark;
  logic                lit;
  logic [NDIG-1:0]     an_nxt;
  logic [SEG_W-1:0]    seg_nxt;

  // Frame boundary: last dwell of the last digit.
  assign frame_start = ce_tick && (idx == IDX_W'(NDIG - 1));
  assign cur_nib     = nib_snap[idx];

  sevenseg_hex_decode u_dec (
    .nib     (cur_nib),
    .glyph_c (glyph)
  );

  // Leading-zero mask: digit i>0 is suppressed while every nibble from the top down to i is 0.
  always_comb begin
    supp     = '0;
    zero_run = lz_snap;
    for (int i = int'(NDIG) - 1; i > 0; i--) begin
      zero_run = zero_run && (nib_snap[i] == 4'h0);
      supp[i]  = zero_run;
    end
  end

  // Next output levels from the current digit and PWM position.
  always_comb begin
    an_nxt  = '0;
    seg_nxt = '0;
    // Count 0 is the dead cycle; the held saturated count is off so full
    // brightness gives exactly 2**PWM_BITS-1 on-cycles per dwell.
    pwm_on  = (pwm_cnt != '0) && (pwm_cnt <= bright) && !pwm_sat;
    dark    = blank_snap[idx] || (blink_snap[idx] && !blink_on) || supp[idx];
    lit     = pwm_on && !dark;
    for (int i = 0; i < int'(NDIG); i++) begin
      an_nxt[i] = pol_bit(lit && (idx == IDX_W'(i)), AN_LOW);
    end
    seg_nxt = pol_seg(lit ? {dp_snap[idx], glyph} : '0, SEG_LOW);
  end

  // Prescaler, scan index, PWM counter, blink timing, snapshots and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      ce_tick    <= 1'b0;
      idx        <= '0;
      pwm_cnt    <= '0;
      pwm_sat    <= 1'b0;
      frame_cnt  <= '0;
      blink_on   <= 1'b1;
      for (int i = 0; i < int'(NDIG); i++) begin
        nib_snap[i] <= 4'h0;
      end
      dp_snap    <= '0;
      blank_snap <= '0;
      blink_snap <= '0;
      lz_snap    <= 1'b0;
      an         <= {NDIG{AN_LOW}};
      seg        <= {SEG_W{SEG_LOW}};
    end else begin
      // ce_tick is registered one cycle early so it is high exactly while presc == DIV-1.
      presc   <= ce_tick ? '0 : presc + PRESC_W'(1);
      ce_tick <= (presc == PRESC_W'(DIV - 2));

      if (ce_tick) begin
        pwm_cnt <= '0;
        pwm_sat <= 1'b0;
        idx     <= frame_start ? '0 : idx + IDX_W'(1);
      end else begin
        if (pwm_cnt != PWM_MAX) begin
          pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
        pwm_sat <= (pwm_cnt == PWM_MAX);
      end

      if (frame_start) begin
        for (int i = 0; i < int'(NDIG); i++) begin
          nib_snap[i] <= dat[4*i +: 4];
        end
        dp_snap    <= dp;
        blank_snap <= blank;
        blink_snap <= blink;
        lz_snap    <= lz_en;
        if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_on  <= !blink_on;
        end else begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end

      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl: DIV=32, NDIG=4, PWM_BITS=4,
// BLINK_FRAMES=2, active-low anodes and segments.
module tb_sevenseg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 32;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dat = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  blink = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  bright = 4'h0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        ce_tick;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(
    .CLKFREQ      (1000000),
    .NDIG         (4),
    .SCAN_US      (32),
    .PWM_BITS     (4),
    .BLINK_FRAMES (2),
    .AN_ACT_LOW   (1),
    .SEG_ACT_LOW  (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dat     (dat),
    .dp      (dp),
    .blank   (blank),
    .blink   (blink),
    .lz_en   (lz_en),
    .bright  (bright),
    .an      (an),
    .seg     (seg),
    .ce_tick (ce_tick)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Per-frame observation results
  int         obs_cnt   [NDIG];
  int         obs_first [NDIG];
  int         obs_last  [NDIG];
  logic [7:0] obs_seg   [NDIG];
  int         obs_bad;
  // Per-test expectations (hand-computed)
  int         ec [NDIG];
  logic [7:0] es [NDIG];

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic skip_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Sample one full frame (FRAME cycles, #1 after each edge); optionally change dat mid-frame.
  task automatic observe_frame(input int mid_s, input logic [15:0] mid_dat);
    logic [3:0] act;
    int d;
    for (int i = 0; i < NDIG; i++) begin
      obs_cnt[i] = 0; obs_first[i] = -1; obs_last[i] = -1; obs_seg[i] = 8'hFF;
    end
    obs_bad = 0;
    for (int s = 0; s < FRAME; s++) begin
      @(posedge clk); #1;
      act = ~an;
      if ($countones(act) > 1) obs_bad++;
      else if (act == 4'h0) begin
        if (seg !== 8'hFF) obs_bad++;
      end else begin
        d = 0;
        for (int i = 0; i < NDIG; i++) if (act[i]) d = i;
        if (d != s / DIV) obs_bad++;
        if (obs_cnt[d] > 0 && seg !== obs_seg[d]) obs_bad++;
        if (obs_first[d] < 0) obs_first[d] = s;
        obs_last[d] = s;
        obs_seg[d]  = seg;
        obs_cnt[d]++;
      end
      if (s == mid_s) dat = mid_dat;
    end
  endtask

  task automatic test_reset();
    dat = 16'h1234; bright = 4'hF; dp = 4'hF;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (an !== 4'hF) begin tests_failed++; $display("FAIL reset_an: got %h want F", an); end
    tests_run++;
    if (seg !== 8'hFF) begin tests_failed++; $display("FAIL reset_seg: got %h want FF", seg); end
    tests_run++;
    if (ce_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_ce: got %b want 0", ce_tick); end
    rst_n = 1'b1;
    // ce_tick is high only in clk 32 after release (after the 31st edge)
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if (ce_tick !== (c == 31)) begin
        tests_failed++;
        $display("FAIL ce_tick_first edge%0d: got %b want %b", c, ce_tick, (c == 31));
      end
    end
    dp = 4'h0;
  endtask

  task automatic test_scan();
    do_reset();
    dat = 16'h12AF; dp = 4'b0101; blank = 4'h0; blink = 4'h0; lz_en = 1'b0; bright = 4'hF;
    skip_cycles(FRAME);
    observe_frame(-1, 16'h0);
    ec = '{15, 15, 15, 15};
    es = '{8'h0E, 8'h88, 8'h24, 8'hF9};
    for (int d = 0; d < NDIG; d++) begin
      tests_run++;
      if (obs_cnt[d] !== ec[d] || obs_first[d] !== d*DIV+1 || obs_last[d] !== d*DIV+ec[d] || obs_seg[d] !== es[d]) begin
        tests_failed++;
        $display("FAIL scan d%0d: cnt=%0d first=%0d last=%0d seg=%h want cnt=%0d first=%0d last=%0d seg=%h",
                 d, obs_cnt[d], obs_first[d], obs_last[d], obs_seg[d], ec[d], d*DIV+1, d*DIV+ec[d], es[d]);
      end
    end
    tests_run++;
    if (obs_bad !== 0) begin tests_failed++; $display("FAIL scan_sanity: got %0d bad cycles want 0", obs_bad); end
    dp = 4'h0;
  endtask

  task automatic test_lz();
    do_reset();
    dat = 16'h0050; dp = 4'h0; lz_en = 1'b1; bright = 4'hF;
    skip_cycles(FRAME);
    observe_frame(-1, 16'h0);
    ec = '{15, 15, 0, 0};
    es = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
    for (int d = 0; d < NDIG; d++) begin
      tests_run++;
      if (obs_cnt[d] !== ec[d] || (ec[d] > 0 && (obs_first[d] !== d*DIV+1 || obs_seg[d] !== es[d]))) begin
        tests_failed++;
        $display("FAIL lz_0050 d%0d: cnt=%0d first=%0d seg=%h want cnt=%0d first=%0d seg=%h",
                 d, obs_cnt[d], obs_first[d], obs_seg[d], ec[d], d*DIV+1, es[d]);
      end
    end
    // all-zero value: only digit 0 shows "0", with its dp lit
    dat = 16'h0000; dp = 4'b0001;
    skip_cycles(FRAME);
    observe_frame(-1, 16'h0);
    ec = '{15, 0, 0, 0};
    es = '{8'h40, 8'hFF, 8'hFF, 8'hFF};
    for (int d = 0; d < NDIG; d++) begin
      tests_run++;
      if (obs_cnt[d] !== ec[d] || (ec[d] > 0 && obs_seg[d] !== es[d])) begin
        tests_failed++;
        $display("FAIL lz_0000 d%0d: cnt=%0d seg=%h want cnt=%0d seg=%h", d, obs_cnt[d], obs_seg[d], ec[d], es[d]);
      end
    end
    tests_run++;
    if (obs_bad !== 0) begin tests_failed++; $display("FAIL lz_sanity: got %0d bad cycles want 0", obs_bad); end
    lz_en = 1'b0; dp = 4'h0;
  endtask

  task automatic test_no_tear();
    do_reset();
    dat = 16'h1234; bright = 4'hF;
    skip_cycles(FRAME);
    // change dat while digit 2 is being scanned
    observe_frame(2*DIV, 16'hABCD);
    es = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    for (int d = 0; d < NDIG; d++) begin
      tests_run++;
      if (obs_cnt[d] !== 15 || obs_seg[d] !== es[d]) begin
        tests_failed++;
        $display("FAIL tear_old d%0d: cnt=%0d seg=%h want cnt=15 seg=%h", d, obs_cnt[d], obs_seg[d], es[d]);
      end
    end
    observe_frame(-1, 16'h0);
    es = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    for (int d = 0; d < NDIG; d++) begin
      tests_run++;
      if (obs_cnt[d] !== 15 || obs_seg[d] !== es[d]) begin
        tests_failed++;
        $display("FAIL tear_new d%0d: cnt=%0d seg=%h want cnt=15 seg=%h", d, obs_cnt[d], obs_seg[d], es[d]);
      end
    end
    tests_run++;
    if (obs_bad !== 0) begin tests_failed++; $display("FAIL tear_sanity: got %0d bad cycles want 0", obs_bad); end
  endtask

  task automatic test_blink_blank();
    logic [5:0] lit1;
    do_reset();
    dat = 16'h1234; bright = 4'hF; blink = 4'b0010; blank = 4'b1000;
    skip_cycles(FRAME);
    // digit 1 lit in frames 1..6: on, off, off, on, on, off (LSB = frame 1)
    lit1 = 6'b011001;
    for (int f = 0; f < 6; f++) begin
      observe_frame(-1, 16'h0);
      tests_run++;
      if (obs_cnt[1] !== (lit1[f] ? 15 : 0)) begin
        tests_failed++;
        $display("FAIL blink_d1 frame%0d: cnt=%0d want %0d", f+1, obs_cnt[1], lit1[f] ? 15 : 0);
      end
      tests_run++;
      if (obs_cnt[3] !== 0) begin
        tests_failed++;
        $display("FAIL blank_d3 frame%0d: cnt=%0d want 0", f+1, obs_cnt[3]);
      end
      tests_run++;
      if (obs_cnt[0] !== 15 || obs_seg[0] !== 8'h99) begin
        tests_failed++;
        $display("FAIL blink_d0 frame%0d: cnt=%0d seg=%h want cnt=15 seg=99", f+1, obs_cnt[0], obs_seg[0]);
      end
    end
    blink = 4'h0; blank = 4'h0;
  endtask

  task automatic test_bright();
    do_reset();
    dat = 16'h8888; bright = 4'h0;
    skip_cycles(FRAME);
    observe_frame(-1, 16'h0);
    for (int d = 0; d < NDIG; d++) begin
      tests_run++;
      if (obs_cnt[d] !== 0) begin
        tests_failed++;
        $display("FAIL bright0 d%0d: cnt=%0d want 0", d, obs_cnt[d]);
      end
    end
    tests_run++;
    if (obs_bad !== 0) begin tests_failed++; $display("FAIL bright0_idle: got %0d bad cycles want 0", obs_bad); end
    // brightness is live: takes effect without a new frame snapshot
    bright = 4'd4;
    observe_frame(-1, 16'h0);
    for (int d = 0; d < NDIG; d++) begin
      tests_run++;
      if (obs_cnt[d] !== 4 || obs_first[d] !== d*DIV+1 || obs_last[d] !== d*DIV+4 || obs_seg[d] !== 8'h80) begin
        tests_failed++;
        $display("FAIL bright4 d%0d: cnt=%0d first=%0d last=%0d seg=%h want cnt=4 first=%0d last=%0d seg=80",
                 d, obs_cnt[d], obs_first[d], obs_last[d], obs_seg[d], d*DIV+1, d*DIV+4);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dat = 16'h1234; bright = 4'hF;
    skip_cycles(40);
    @(negedge clk);
    tests_run++;
    if (an !== 4'b1101) begin tests_failed++; $display("FAIL midrst_pre_an: got %h want D", an); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (an !== 4'hF || seg !== 8'hFF || ce_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: an=%h seg=%h ce=%b want an=F seg=FF ce=0", an, seg, ce_tick);
    end
    @(negedge clk); rst_n = 1'b1;
    // first frame after reset shows the cleared snapshot "0000", starting at digit 0
    observe_frame(-1, 16'h0);
    for (int d = 0; d < NDIG; d++) begin
      tests_run++;
      if (obs_cnt[d] !== 15 || obs_first[d] !== d*DIV+1 || obs_seg[d] !== 8'hC0) begin
        tests_failed++;
        $display("FAIL midrst_restart d%0d: cnt=%0d first=%0d seg=%h want cnt=15 first=%0d seg=C0",
                 d, obs_cnt[d], obs_first[d], obs_seg[d], d*DIV+1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_no_tear();
    test_blink_blank();
    test_bright();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
